// File: rtl/clock_set_ctrl.sv
// clock_set_ctrl: button-driven time-setting controller for a 1 Hz clock counter.
//
// A mode press captures the live time and steps through hours, minutes and
// seconds editing. A final mode press commits the edited time with a
// one-cycle setmode strobe. If no button is pressed for TIMEOUT cycles, the
// edit is abandoned without a strobe.
//
// Ports:
//   Clk_1sec     in   sole clock, rising edge
//   reset        in   asynchronous, active-high
//   btn_mode     in   mode button level (synchronous)
//   btn_inc      in   increment button level (synchronous)
//   btn_dec      in   decrement button level (synchronous)
//   cur_hours    in   [5:0] live hours
//   cur_minutes  in   [6:0] live minutes
//   cur_seconds  in   [6:0] live seconds
//   setmode      out  one-cycle load strobe
//   set_hours    out  [5:0] hours to load
//   set_minutes  out  [6:0] minutes to load
//   set_seconds  out  [6:0] seconds to load
//   field_sel    out  [1:0] 0 none, 1 hours, 2 minutes, 3 seconds
//   blink        out  blink enable for the selected field
module clock_set_ctrl #(
    parameter int unsigned TIMEOUT = 30
) (
    input  logic       Clk_1sec,
    input  logic       reset,
    input  logic       btn_mode,
    input  logic       btn_inc,
    input  logic       btn_dec,
    input  logic [5:0] cur_hours,
    input  logic [6:0] cur_minutes,
    input  logic [6:0] cur_seconds,
    output logic       setmode,
    output logic [5:0] set_hours,
    output logic [6:0] set_minutes,
    output logic [6:0] set_seconds,
    output logic [1:0] field_sel,
    output logic       blink
);

    localparam int unsigned CntW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    typedef enum logic [2:0] {StIdle, StSetHr, StSetMin, StSetSec, StCommit} state_e;

    state_e          state_q, state_d;
    logic [5:0]      hr_q, hr_d;
    logic [6:0]      min_q, min_d;
    logic [6:0]      sec_q, sec_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            mode_prev_q, inc_prev_q, dec_prev_q;
    logic            setmode_q, setmode_d;
    logic [1:0]      fsel_q, fsel_d;
    logic            blink_q, blink_d;

    logic mode_press, inc_press, dec_press, any_press, step_up, step_dn;

    // Previous-level registers clear to 0 on reset, so a button held through
    // reset release is seen as one fresh press.
    assign mode_press = btn_mode & ~mode_prev_q;
    assign inc_press  = btn_inc & ~inc_prev_q;
    assign dec_press  = btn_dec & ~dec_prev_q;
    assign any_press  = mode_press | inc_press | dec_press;
    // Simultaneous inc+dec cancels; a mode press swallows both.
    assign step_up    = ~mode_press & inc_press & ~dec_press;
    assign step_dn    = ~mode_press & dec_press & ~inc_press;

    always_comb begin
        state_d = state_q;
        hr_d    = hr_q;
        min_d   = min_q;
        sec_d   = sec_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            StIdle: begin
                if (mode_press) begin
                    state_d = StSetHr;
                    hr_d    = (cur_hours > 6'd23) ? 6'd0 : cur_hours;
                    min_d   = (cur_minutes > 7'd59) ? 7'd0 : cur_minutes;
                    sec_d   = (cur_seconds > 7'd59) ? 7'd0 : cur_seconds;
                    cnt_d   = '0;
                end
            end
            StSetHr, StSetMin, StSetSec: begin
                if (any_press) begin
                    cnt_d = '0;
                end else if (cnt_q == CntW'(TIMEOUT - 1)) begin
                    state_d = StIdle;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
                if (mode_press) begin
                    unique case (state_q)
                        StSetHr:  state_d = StSetMin;
                        StSetMin: state_d = StSetSec;
                        default:  state_d = StCommit;
                    endcase
                end
                if (state_q == StSetHr) begin
                    if (step_up) hr_d = (hr_q == 6'd23) ? 6'd0 : hr_q + 6'd1;
                    if (step_dn) hr_d = (hr_q == 6'd0) ? 6'd23 : hr_q - 6'd1;
                end
                if (state_q == StSetMin) begin
                    if (step_up) min_d = (min_q == 7'd59) ? 7'd0 : min_q + 7'd1;
                    if (step_dn) min_d = (min_q == 7'd0) ? 7'd59 : min_q - 7'd1;
                end
                if (state_q == StSetSec) begin
                    if (step_up) sec_d = (sec_q == 7'd59) ? 7'd0 : sec_q + 7'd1;
                    if (step_dn) sec_d = (sec_q == 7'd0) ? 7'd59 : sec_q - 7'd1;
                end
            end
            StCommit: state_d = StIdle;
            default:  state_d = StIdle;
        endcase
    end

    // Status outputs are registered from the next state so they line up with
    // the state register.
    always_comb begin
        setmode_d = 1'b0;
        fsel_d    = 2'd0;
        blink_d   = 1'b0;
        unique case (state_d)
            StSetHr:  fsel_d = 2'd1;
            StSetMin: fsel_d = 2'd2;
            StSetSec: fsel_d = 2'd3;
            StCommit: setmode_d = 1'b1;
            default:  fsel_d = 2'd0;
        endcase
        if (fsel_d != 2'd0) blink_d = ~blink_q;
    end

    always_ff @(posedge Clk_1sec or posedge reset) begin
        if (reset) begin
            state_q     <= StIdle;
            hr_q        <= '0;
            min_q       <= '0;
            sec_q       <= '0;
            cnt_q       <= '0;
            mode_prev_q <= 1'b0;
            inc_prev_q  <= 1'b0;
            dec_prev_q  <= 1'b0;
            setmode_q   <= 1'b0;
            fsel_q      <= 2'd0;
            blink_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            hr_q        <= hr_d;
            min_q       <= min_d;
            sec_q       <= sec_d;
            cnt_q       <= cnt_d;
            mode_prev_q <= btn_mode;
            inc_prev_q  <= btn_inc;
            dec_prev_q  <= btn_dec;
            setmode_q   <= setmode_d;
            fsel_q      <= fsel_d;
            blink_q     <= blink_d;
        end
    end

    assign setmode     = setmode_q;
    assign set_hours   = hr_q;
    assign set_minutes = min_q;
    assign set_seconds = sec_q;
    assign field_sel   = fsel_q;
    assign blink       = blink_q;

endmodule

// File: tb/tb_clock_set_ctrl.sv
module tb_clock_set_ctrl;

    localparam int unsigned TO = 30;

    logic       Clk_1sec = 1'b0;
    logic       reset;
    logic       btn_mode, btn_inc, btn_dec;
    logic [5:0] cur_hours;
    logic [6:0] cur_minutes, cur_seconds;
    logic       setmode;
    logic [5:0] set_hours;
    logic [6:0] set_minutes, set_seconds;
    logic [1:0] field_sel;
    logic       blink;

    clock_set_ctrl #(.TIMEOUT(TO)) dut (
        .Clk_1sec   (Clk_1sec),
        .reset      (reset),
        .btn_mode   (btn_mode),
        .btn_inc    (btn_inc),
        .btn_dec    (btn_dec),
        .cur_hours  (cur_hours),
        .cur_minutes(cur_minutes),
        .cur_seconds(cur_seconds),
        .setmode    (setmode),
        .set_hours  (set_hours),
        .set_minutes(set_minutes),
        .set_seconds(set_seconds),
        .field_sel  (field_sel),
        .blink      (blink)
    );

    always #5 Clk_1sec = ~Clk_1sec;

    typedef struct {
        string      tag;
        logic       sm;
        logic [1:0] fs;
        logic       bl;
        logic [5:0] h;
        logic [6:0] m;
        logic [6:0] s;
    } exp_t;

    exp_t sb_q[$];
    int   total = 0;
    int   bad   = 0;
    logic exp_blink = 1'b0;

    task automatic chk(input string tag, input string what, input logic [31:0] obs,
                       input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s.%s: got %0d expected %0d", tag, what, obs, expv);
        end
    endtask

    task automatic check_all(input exp_t e);
        chk(e.tag, "setmode", 32'(setmode), 32'(e.sm));
        chk(e.tag, "field_sel", 32'(field_sel), 32'(e.fs));
        chk(e.tag, "blink", 32'(blink), 32'(e.bl));
        chk(e.tag, "hours", 32'(set_hours), 32'(e.h));
        chk(e.tag, "minutes", 32'(set_minutes), 32'(e.m));
        chk(e.tag, "seconds", 32'(set_seconds), 32'(e.s));
    endtask

    // Drive buttons for one cycle; expected outputs after the next edge are queued
    // with the stimulus and compared at the following falling edge.
    task automatic step(input logic m, input logic i, input logic d, input logic [1:0] fs,
                        input logic sm, input int h, input int mi, input int s,
                        input string tag);
        exp_t e;
        exp_blink = (fs != 2'd0) ? ~exp_blink : 1'b0;
        e.tag = tag;
        e.sm  = sm;
        e.fs  = fs;
        e.bl  = exp_blink;
        e.h   = h[5:0];
        e.m   = mi[6:0];
        e.s   = s[6:0];
        sb_q.push_back(e);
        btn_mode = m;
        btn_inc  = i;
        btn_dec  = d;
        @(negedge Clk_1sec);
        if (sb_q.size() == 0) begin
            total++;
            bad++;
            $error("FAIL %s.queue: got empty expected entry", tag);
        end else begin
            check_all(sb_q.pop_front());
        end
    endtask

    initial begin
        exp_t z;
        reset       = 1'b1;
        btn_mode    = 1'b0;
        btn_inc     = 1'b0;
        btn_dec     = 1'b0;
        cur_hours   = 6'd6;
        cur_minutes = 7'd6;
        cur_seconds = 7'd6;
        @(negedge Clk_1sec);
        @(negedge Clk_1sec);
        z.tag = "reset"; z.sm = 0; z.fs = 0; z.bl = 0; z.h = 0; z.m = 0; z.s = 0;
        check_all(z);
        reset = 1'b0;

        // Full edit of 06:06:06, two hour increments, commit.
        step(1, 0, 0, 1, 0, 6, 6, 6, "a_enter");
        step(0, 0, 0, 1, 0, 6, 6, 6, "a_rel");
        step(0, 1, 0, 1, 0, 7, 6, 6, "a_inc1");
        step(0, 0, 0, 1, 0, 7, 6, 6, "a_rel");
        step(0, 1, 0, 1, 0, 8, 6, 6, "a_inc2");
        step(0, 0, 0, 1, 0, 8, 6, 6, "a_rel");
        step(1, 0, 0, 2, 0, 8, 6, 6, "a_min");
        step(0, 0, 0, 2, 0, 8, 6, 6, "a_rel");
        step(1, 0, 0, 3, 0, 8, 6, 6, "a_sec");
        step(0, 0, 0, 3, 0, 8, 6, 6, "a_rel");
        step(1, 0, 0, 0, 1, 8, 6, 6, "a_commit");
        step(0, 0, 0, 0, 0, 8, 6, 6, "a_idle");
        step(0, 0, 0, 0, 0, 8, 6, 6, "a_hold");

        // Wrap boundaries.
        cur_hours = 6'd23; cur_minutes = 7'd0; cur_seconds = 7'd59;
        step(1, 0, 0, 1, 0, 23, 0, 59, "b_enter");
        step(0, 0, 0, 1, 0, 23, 0, 59, "b_rel");
        step(0, 1, 0, 1, 0, 0, 0, 59, "b_hr_wrap");
        step(0, 0, 0, 1, 0, 0, 0, 59, "b_rel");
        step(1, 0, 0, 2, 0, 0, 0, 59, "b_min");
        step(0, 0, 0, 2, 0, 0, 0, 59, "b_rel");
        step(0, 0, 1, 2, 0, 0, 59, 59, "b_min_wrap");
        step(0, 0, 0, 2, 0, 0, 59, 59, "b_rel");
        step(1, 0, 0, 3, 0, 0, 59, 59, "b_sec");
        step(0, 0, 0, 3, 0, 0, 59, 59, "b_rel");
        step(0, 1, 0, 3, 0, 0, 59, 0, "b_sec_wrap");
        step(0, 0, 0, 3, 0, 0, 59, 0, "b_rel");
        step(1, 0, 0, 0, 1, 0, 59, 0, "b_commit");
        step(0, 0, 0, 0, 0, 0, 59, 0, "b_idle");

        // Out-of-range capture, inc+dec cancel, mode+inc, then timeout in SET_MIN.
        cur_hours = 6'd24; cur_minutes = 7'd60; cur_seconds = 7'd127;
        step(1, 0, 0, 1, 0, 0, 0, 0, "c_clamp");
        step(0, 0, 0, 1, 0, 0, 0, 0, "c_rel");
        step(0, 1, 1, 1, 0, 0, 0, 0, "c_incdec");
        step(0, 0, 0, 1, 0, 0, 0, 0, "c_rel");
        step(1, 1, 0, 2, 0, 0, 0, 0, "c_mode_inc");
        for (int k = 1; k < int'(TO); k++) step(0, 0, 0, 2, 0, 0, 0, 0, "c_wait");
        step(0, 0, 0, 0, 0, 0, 0, 0, "c_timeout");
        step(0, 0, 0, 0, 0, 0, 0, 0, "c_no_commit");
        step(0, 1, 0, 0, 0, 0, 0, 0, "c_idle_inc");
        step(0, 0, 1, 0, 0, 0, 0, 0, "c_idle_dec");
        step(0, 0, 0, 0, 0, 0, 0, 0, "c_rel");

        // Held inc counts once.
        cur_hours = 6'd10; cur_minutes = 7'd20; cur_seconds = 7'd30;
        step(1, 0, 0, 1, 0, 10, 20, 30, "d_enter");
        step(0, 0, 0, 1, 0, 10, 20, 30, "d_rel");
        for (int k = 0; k < 10; k++) step(0, 1, 0, 1, 0, 11, 20, 30, "d_hold");
        step(0, 0, 0, 1, 0, 11, 20, 30, "d_rel");

        // Reset during SET_SEC.
        step(1, 0, 0, 2, 0, 11, 20, 30, "e_min");
        step(0, 0, 0, 2, 0, 11, 20, 30, "e_rel");
        step(1, 0, 0, 3, 0, 11, 20, 30, "e_sec");
        step(0, 0, 0, 3, 0, 11, 20, 30, "e_rel");
        #2 reset = 1'b1;
        #1;
        z.tag = "e_async_rst";
        check_all(z);
        exp_blink = 1'b0;
        @(negedge Clk_1sec);
        reset = 1'b0;
        step(0, 0, 0, 0, 0, 0, 0, 0, "e_idle");

        // Mode held through reset release counts as one press.
        reset    = 1'b1;
        btn_mode = 1'b1;
        @(negedge Clk_1sec);
        reset = 1'b0;
        step(1, 0, 0, 1, 0, 10, 20, 30, "f_held_press");
        step(1, 0, 0, 1, 0, 10, 20, 30, "f_still_held");
        step(0, 0, 0, 1, 0, 10, 20, 30, "f_rel");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
